bank_load_port: RTL

Responder for the staging memory-load interface. Accepts a requester's write or read of one TX_DATA_WIDTH-bit column slice of a grid row, and performs read-modify-write into the row-interleaved bank array (a write) or returns the slice (a read). It drives the mem_ack_out / mem_busy_out handshake back to the requester. It sits between the external pad/packet interface and the bank instances inside top.

---
 rtl/bank_load_port_pkg.sv | 49 ++++
 rtl/bank_row_merge.sv | 42 ++++
 rtl/bank_load_port.sv | 117 +++++++++++
 3 files changed

// File: rtl/bank_load_port_pkg.sv
// Shared constants, FSM state type and request helpers for the staging-memory load port.
package bank_load_port_pkg;

    localparam int MAX_ROWS        = 140;
    localparam int MAX_COLS        = 140;
    localparam int TX_DATA_WIDTH   = 32;
    localparam int NUM_BANKS       = 3;
    localparam int BANK_DEPTH      = (MAX_ROWS + NUM_BANKS - 1) / NUM_BANKS;
    localparam int ROW_ADDR_WIDTH  = $clog2(MAX_ROWS);
    localparam int COL_ADDR_WIDTH  = $clog2(MAX_COLS);
    localparam int BANK_SEL_WIDTH  = $clog2(NUM_BANKS);
    localparam int BANK_ADDR_WIDTH = $clog2(BANK_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        ACK,
        RELEASE
    } load_state_t;

    typedef struct packed {
        logic                      is_write;
        logic [COL_ADDR_WIDTH-1:0] col;
        logic [TX_DATA_WIDTH-1:0]  vec;
    } load_req_t;

    function automatic logic req_legal(
        input logic [ROW_ADDR_WIDTH-1:0] row,
        input logic [COL_ADDR_WIDTH-1:0] col,
        input logic                      wr,
        input logic                      rd
    );
        return (int'(row) < MAX_ROWS) &&
               (int'(col) < MAX_COLS) &&
               ((int'(col) % TX_DATA_WIDTH) == 0) &&
               !(wr && rd);
    endfunction

    // Rows are interleaved across banks: consecutive rows land in consecutive banks.
    function automatic logic [BANK_SEL_WIDTH-1:0] bank_of(input logic [ROW_ADDR_WIDTH-1:0] row);
        return BANK_SEL_WIDTH'(int'(row) % NUM_BANKS);
    endfunction

    function automatic logic [BANK_ADDR_WIDTH-1:0] entry_of(input logic [ROW_ADDR_WIDTH-1:0] row);
        return BANK_ADDR_WIDTH'(int'(row) / NUM_BANKS);
    endfunction

endpackage

// File: rtl/bank_row_merge.sv
// Slice insert into a bank row (writes) and slice extract with zero fill past the row end (reads).
// Purely combinational; slice bits that fall beyond ROW_W are dropped on insert and read as 0 on extract.
module bank_row_merge #(
    parameter int ROW_W   = 140,
    parameter int SLICE_W = 32,
    parameter int COL_W   = 8
) (
    input  logic [ROW_W-1:0]   row_in,
    input  logic [COL_W-1:0]   col,
    input  logic [SLICE_W-1:0] slice_in,
    output logic [ROW_W-1:0]   row_out,
    output logic [SLICE_W-1:0] slice_out
);

    localparam int SLICE_IDX_W = $clog2(SLICE_W);
    localparam int ROW_IDX_W   = $clog2(ROW_W);

    always_comb begin
        int off;
        off     = 0;
        row_out = row_in;
        for (int i = 0; i < ROW_W; i++) begin
            off = i - int'(col);
            if (off >= 0 && off < SLICE_W) begin
                row_out[i] = slice_in[off[SLICE_IDX_W-1:0]];
            end
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        slice_out = '0;
        for (int j = 0; j < SLICE_W; j++) begin
            idx = int'(col) + j;
            if (idx < ROW_W) begin
                slice_out[j] = row_in[idx[ROW_IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/bank_load_port.sv
// Load-port responder: read-modify-write of one column slice into the row-interleaved bank array, or slice read-back.
// Latency: bank read 1 cycle after accept, bank write 2 cycles after, ack from 3; ack held until the requester drops req.
module bank_load_port
    import bank_load_port_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pad_en,
    input  logic                       write_en,
    input  logic                       read_en,
    input  logic [ROW_ADDR_WIDTH-1:0]  row_addr,
    input  logic [COL_ADDR_WIDTH-1:0]  col_addr,
    input  logic [TX_DATA_WIDTH-1:0]   partial_vec,
    output logic                       mem_ack_out,
    output logic                       mem_busy_out,
    output logic                       err_out,
    output logic [TX_DATA_WIDTH-1:0]   rd_data_out,
    output logic [BANK_SEL_WIDTH-1:0]  bank_sel,
    output logic [BANK_ADDR_WIDTH-1:0] bank_addr,
    output logic                       bank_rd_en,
    input  logic [MAX_COLS-1:0]        bank_rd_data,
    output logic                       bank_wr_en,
    output logic [MAX_COLS-1:0]        bank_wr_data
);

    load_state_t               state;
    load_state_t               state_nxt;
    load_req_t                 req_q;
    logic                      req;
    logic                      legal;
    logic                      accept;
    logic [MAX_COLS-1:0]       merged_row;
    logic [TX_DATA_WIDTH-1:0]  read_slice;

    assign req    = pad_en & (write_en | read_en);
    assign legal  = req_legal(row_addr, col_addr, write_en, read_en);
    assign accept = (state == IDLE) && req;

    bank_row_merge #(
        .ROW_W   (MAX_COLS),
        .SLICE_W (TX_DATA_WIDTH),
        .COL_W   (COL_ADDR_WIDTH)
    ) u_merge (
        .row_in    (bank_rd_data),
        .col       (req_q.col),
        .slice_in  (req_q.vec),
        .row_out   (merged_row),
        .slice_out (read_slice)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= '0;
            bank_sel    <= '0;
            bank_addr   <= '0;
            err_out     <= 1'b0;
            rd_data_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q.is_write <= write_en;
                req_q.col      <= col_addr;
                req_q.vec      <= partial_vec;
                // A rejected row may be out of range; park the bank address at 0 instead.
                bank_sel       <= legal ? bank_of(row_addr)  : '0;
                bank_addr      <= legal ? entry_of(row_addr) : '0;
                err_out        <= !legal;
                rd_data_out    <= '0;
            end else if (state == MERGE && !req_q.is_write) begin
                rd_data_out    <= read_slice;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bank_rd_en   = 1'b0;
        bank_wr_en   = 1'b0;
        bank_wr_data = '0;
        mem_ack_out  = 1'b0;
        mem_busy_out = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = legal ? READ : ACK;
                end
            end
            READ: begin
                bank_rd_en   = !reset;
                mem_busy_out = 1'b1;
                state_nxt    = MERGE;
            end
            MERGE: begin
                // Reset landing on the merge cycle must not corrupt the bank row.
                bank_wr_en   = req_q.is_write && !reset;
                bank_wr_data = bank_wr_en ? merged_row : '0;
                mem_busy_out = 1'b1;
                state_nxt    = ACK;
            end
            ACK: begin
                mem_ack_out  = 1'b1;
                mem_busy_out = 1'b1;
                if (!req) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
